// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses instruction memory and holds one IF/ID slot toward decode.
// Optional macro IFETCH_MISALIGN_CHECK_EN enables the sticky misaligned-redirect error.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [31:0] fetch_count,
  output logic        fetch_err
);

  logic [31:0] pc_p0, pc_p0_nxt;
  logic        vld_p1, vld_p1_nxt;
  logic [31:0] pc_p1, pc_p1_nxt;
  logic [31:0] instr_p1, instr_p1_nxt;
  logic [31:0] count;
  logic        err;
  logic        slot_free;
  logic        handoff;
  logic        fetch_block;
  logic        redirect_take;
  logic [31:0] redirect_target;

  assign slot_free = !vld_p1 || out_ready;
  assign handoff   = vld_p1 && out_ready;

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic misalign;
  // Once the error is latched the stage freezes fetching and ignores redirects until reset.
  assign misalign        = redirect_valid && !err && (redirect_pc[1:0] != 2'b00);
  assign fetch_block     = halt || err;
  assign redirect_take   = redirect_valid && !err;
  assign redirect_target = redirect_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (misalign) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_redirect_low;
  assign unused_redirect_low = ^redirect_pc[1:0];
  assign fetch_block     = halt;
  assign redirect_take   = redirect_valid;
  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign err             = 1'b0;
`endif

  always_comb begin
    pc_p0_nxt    = pc_p0;
    vld_p1_nxt   = vld_p1;
    pc_p1_nxt    = pc_p1;
    instr_p1_nxt = instr_p1;
    if (redirect_take) begin
      // Flush wins over stall; out_pc keeps its last value.
      pc_p0_nxt    = redirect_target;
      vld_p1_nxt   = 1'b0;
      instr_p1_nxt = NOP_INSTR;
    end else if (!fetch_block && slot_free) begin
      pc_p0_nxt    = pc_p0 + 32'd4;
      vld_p1_nxt   = 1'b1;
      pc_p1_nxt    = pc_p0;
      instr_p1_nxt = imem_instr;
    end else if (slot_free) begin
      vld_p1_nxt   = 1'b0;
      instr_p1_nxt = NOP_INSTR;
    end
  end

  // ---- stage p0: program counter driving instruction memory ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_p0 <= RESET_PC;
    end else begin
      pc_p0 <= pc_p0_nxt;
    end
  end

  // ---- stage p1: IF/ID output slot ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      pc_p1    <= 32'h0000_0000;
      instr_p1 <= NOP_INSTR;
      count    <= 32'h0000_0000;
    end else begin
      vld_p1   <= vld_p1_nxt;
      pc_p1    <= pc_p1_nxt;
      instr_p1 <= instr_p1_nxt;
      if (handoff) begin
        count <= count + 32'd1;
      end
    end
  end

  assign imem_addr   = pc_p0;
  assign out_valid   = vld_p1;
  assign out_pc      = pc_p1;
  assign out_instr   = instr_p1;
  assign fetch_count = count;
  assign fetch_err   = err;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: streaming, stall, redirect, halt drain, wrap and misaligned redirect.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] fetch_count;
  logic        fetch_err;

  logic [31:0] mem [0:255];
  int n_checks;
  int n_fail;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] W0  = 32'h0050_0093;
  localparam logic [31:0] W1  = 32'h00A0_0113;
  localparam logic [31:0] W2  = 32'h0020_81B3;
  localparam logic [31:0] W3  = 32'h0000_006F;

  instruction_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .fetch_count    (fetch_count),
    .fetch_err      (fetch_err)
  );

  assign imem_instr = mem[imem_addr[9:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_slot(input string tag, input logic vld, input logic [31:0] pc,
                            input logic [31:0] instr, input logic [31:0] cnt);
    check_val({tag, ".valid"}, {31'd0, out_valid}, {31'd0, vld});
    check_val({tag, ".pc"}, out_pc, pc);
    check_val({tag, ".instr"}, out_instr, instr);
    check_val({tag, ".count"}, fetch_count, cnt);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
    mem[0] = W0;
    mem[1] = W1;
    mem[2] = W2;
    mem[3] = W3;

    rst_n = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
    #2;
    step();
    step();
    check_slot("reset", 1'b0, 32'h0, NOP, 32'd0);
    check_val("reset.err", {31'd0, fetch_err}, 32'd0);
    check_val("reset.addr", imem_addr, 32'h0);

    // Stream 0x0..0xC with decode always ready
    rst_n = 1'b1;
    step(); check_slot("s1", 1'b1, 32'h0, W0, 32'd0);
    check_val("s1.addr", imem_addr, 32'h4);
    step(); check_slot("s2", 1'b1, 32'h4, W1, 32'd1);
    step(); check_slot("s3", 1'b1, 32'h8, W2, 32'd2);
    step(); check_slot("s4", 1'b1, 32'hC, W3, 32'd3);
    step(); check_slot("s5", 1'b1, 32'h10, 32'hA500_0004, 32'd4);

    // Redirect back to 0x8 with a completed handoff in the same cycle
    redirect_valid = 1'b1; redirect_pc = 32'h8;
    step(); check_slot("rd8", 1'b0, 32'h10, NOP, 32'd5);
    redirect_valid = 1'b0;
    step(); check_slot("rd8.f", 1'b1, 32'h8, W2, 32'd5);

    // Stall three cycles holding 0x8
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_slot("stall", 1'b1, 32'h8, W2, 32'd5);
      check_val("stall.addr", imem_addr, 32'hC);
    end
    out_ready = 1'b1;
    step(); check_slot("unstall", 1'b1, 32'hC, W3, 32'd6);
    step(); check_slot("unstall2", 1'b1, 32'h10, 32'hA500_0004, 32'd7);

    // Redirect while stalled: flush without counting
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
    step(); check_slot("rdst", 1'b0, 32'h10, NOP, 32'd7);
    redirect_valid = 1'b0; out_ready = 1'b1;
    step(); check_slot("rdst.f", 1'b1, 32'h40, 32'hA500_0010, 32'd7);

    // Halt drains the full slot then holds pc
    halt = 1'b1;
    step(); check_slot("halt1", 1'b0, 32'h40, NOP, 32'd8);
    check_val("halt1.addr", imem_addr, 32'h44);
    step(); check_slot("halt2", 1'b0, 32'h40, NOP, 32'd8);
    check_val("halt2.addr", imem_addr, 32'h44);
    halt = 1'b0;
    step(); check_slot("resume", 1'b1, 32'h44, 32'hA500_0011, 32'd8);

    // PC wraps modulo 2^32
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(); check_slot("wrap.rd", 1'b0, 32'h44, NOP, 32'd9);
    redirect_valid = 1'b0;
    step(); check_slot("wrap1", 1'b1, 32'hFFFF_FFFC, 32'hA500_00FF, 32'd9);
    step(); check_slot("wrap2", 1'b1, 32'h0, W0, 32'd10);
    check_val("wrap2.addr", imem_addr, 32'h4);

    // Redirect together with halt: slot stays empty until halt drops
    halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    step(); check_slot("rdh", 1'b0, 32'h0, NOP, 32'd11);
    redirect_valid = 1'b0;
    step(); check_slot("rdh2", 1'b0, 32'h0, NOP, 32'd11);
    check_val("rdh2.addr", imem_addr, 32'h40);
    halt = 1'b0;
    step(); check_slot("rdh3", 1'b1, 32'h40, 32'hA500_0010, 32'd11);

    // Misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    step(); check_slot("mis.rd", 1'b0, 32'h40, NOP, 32'd12);
    redirect_valid = 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
    check_val("mis.err", {31'd0, fetch_err}, 32'd1);
    check_val("mis.addr", imem_addr, 32'h42);
    step(); check_slot("mis.hold", 1'b0, 32'h40, NOP, 32'd12);
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    step(); redirect_valid = 1'b0;
    check_val("mis.ignore", imem_addr, 32'h42);
    check_val("mis.err2", {31'd0, fetch_err}, 32'd1);
    check_val("mis.vld", {31'd0, out_valid}, 32'd0);
`else
    check_val("mis.err", {31'd0, fetch_err}, 32'd0);
    check_val("mis.addr", imem_addr, 32'h40);
    step(); check_slot("mis.f", 1'b1, 32'h40, 32'hA500_0010, 32'd12);
    check_val("mis.err2", {31'd0, fetch_err}, 32'd0);
`endif

    // Reset mid-stall clears everything
    out_ready = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    check_slot("rst2", 1'b0, 32'h0, NOP, 32'd0);
    check_val("rst2.err", {31'd0, fetch_err}, 32'd0);
    check_val("rst2.addr", imem_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
